// File: rtl/ym_pcma_sched.sv
// PCMA channel scheduler: round-robins six ADPCM channels over SLOT_TICKs,
// fetches sample bytes from ROM and emits one 4-bit nibble per served slot.
module ym_pcma_sched (
  input  logic        PHI_M,
  input  logic        RESET,
  input  logic        SLOT_TICK,
  input  logic [5:0]  KEYON,
  input  logic [5:0]  KEYOFF,
  input  logic [95:0] START,
  input  logic [95:0] STOP,
  input  logic [5:0]  FLAGMASK,
  input  logic [5:0]  FLAG_CLR,
  output logic        ROM_REQ,
  output logic [23:0] ROM_ADDR,
  input  logic        ROM_ACK,
  input  logic [7:0]  ROM_DATA,
  output logic        NIB_VALID,
  output logic [2:0]  NIB_CH,
  output logic [3:0]  NIB_DATA,
  output logic        NIB_FIRST,
  output logic [5:0]  FLAGS,
  output logic        OVERRUN
);

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, EMIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  ch_q, ch_d;
  logic        abort_q, abort_d;
  logic [5:0]  active_q, active_d;
  logic [5:0]  nib_sel_q, nib_sel_d;
  logic [5:0]  first_q, first_d;
  logic [5:0]  flags_q, flags_d;
  logic [23:0] addr_q [6];
  logic [23:0] addr_d [6];
  logic [7:0]  buf_q [6];
  logic [7:0]  buf_d [6];
  logic        rom_req_q, rom_req_d;
  logic [23:0] rom_addr_q, rom_addr_d;
  logic        nib_valid_q, nib_valid_d;
  logic [2:0]  nib_ch_q, nib_ch_d;
  logic [3:0]  nib_data_q, nib_data_d;
  logic        nib_first_q, nib_first_d;
  logic        overrun_q, overrun_d;

  logic        key_hit;
  logic [23:0] stop_addr;
  logic [5:0]  flag_set;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    abort_d     = abort_q;
    active_d    = active_q;
    nib_sel_d   = nib_sel_q;
    first_d     = first_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    rom_req_d   = 1'b0;
    rom_addr_d  = rom_addr_q;
    nib_valid_d = 1'b0;
    nib_ch_d    = nib_ch_q;
    nib_data_d  = nib_data_q;
    nib_first_d = nib_first_q;
    overrun_d   = SLOT_TICK && (state_q != IDLE);
    flag_set    = '0;
    key_hit     = KEYON[ch_q] | KEYOFF[ch_q];
    stop_addr   = {STOP[{ch_q, 4'b0000} +: 16], 8'hFF};

    case (state_q)
      IDLE: begin
        if (SLOT_TICK) begin
          ch_d    = ptr_q;
          ptr_d   = (ptr_q == 3'd5) ? 3'd0 : ptr_q + 3'd1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        abort_d = 1'b0;
        if (!active_q[ch_q] || key_hit) begin
          state_d = IDLE;
        end else if (!nib_sel_q[ch_q]) begin
          state_d    = FETCH;
          rom_req_d  = 1'b1;
          rom_addr_d = addr_q[ch_q];
        end else begin
          // Low nibble straight from the buffer; stop check happens here.
          state_d     = EMIT;
          nib_valid_d = 1'b1;
          nib_ch_d    = ch_q;
          nib_data_d  = buf_q[ch_q][3:0];
          nib_first_d = first_q[ch_q];
          first_d[ch_q] = 1'b0;
          if (addr_q[ch_q] == stop_addr) begin
            active_d[ch_q] = 1'b0;
            flag_set[ch_q] = ~FLAGMASK[ch_q];
          end else begin
            addr_d[ch_q]    = addr_q[ch_q] + 24'd1;
            nib_sel_d[ch_q] = 1'b0;
          end
        end
      end

      FETCH: begin
        rom_req_d = 1'b1;
        if (key_hit) abort_d = 1'b1;
        if (ROM_ACK) begin
          rom_req_d = 1'b0;
          if (abort_q || key_hit) begin
            state_d = IDLE;
          end else begin
            state_d         = EMIT;
            buf_d[ch_q]     = ROM_DATA;
            nib_valid_d     = 1'b1;
            nib_ch_d        = ch_q;
            nib_data_d      = ROM_DATA[7:4];
            nib_first_d     = first_q[ch_q];
            nib_sel_d[ch_q] = 1'b1;
            first_d[ch_q]   = 1'b0;
          end
        end
      end

      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    flags_d = (flags_q & ~FLAG_CLR) | flag_set;

    // Key events override any slot update; key-off beats key-on.
    for (int i = 0; i < 6; i++) begin
      if (KEYOFF[i]) begin
        active_d[i] = 1'b0;
      end else if (KEYON[i]) begin
        active_d[i]  = 1'b1;
        addr_d[i]    = {START[16*i +: 16], 8'h00};
        nib_sel_d[i] = 1'b0;
        first_d[i]   = 1'b1;
        flags_d[i]   = 1'b0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge PHI_M) begin
    if (RESET) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      ch_q        <= 3'd0;
      abort_q     <= 1'b0;
      active_q    <= '0;
      nib_sel_q   <= '0;
      first_q     <= '0;
      flags_q     <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      nib_valid_q <= 1'b0;
      nib_ch_q    <= '0;
      nib_data_q  <= '0;
      nib_first_q <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the per-channel arrays are tiny flop banks, not RAM, so they
      // are reset with everything else for a clean post-reset state.
      for (int i = 0; i < 6; i++) begin
        addr_q[i] <= '0;
        buf_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      abort_q     <= abort_d;
      active_q    <= active_d;
      nib_sel_q   <= nib_sel_d;
      first_q     <= first_d;
      flags_q     <= flags_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
      nib_valid_q <= nib_valid_d;
      nib_ch_q    <= nib_ch_d;
      nib_data_q  <= nib_data_d;
      nib_first_q <= nib_first_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < 6; i++) begin
        addr_q[i] <= addr_d[i];
        buf_q[i]  <= buf_d[i];
      end
    end
  end

  assign ROM_REQ   = rom_req_q;
  assign ROM_ADDR  = rom_addr_q;
  assign NIB_VALID = nib_valid_q;
  assign NIB_CH    = nib_ch_q;
  assign NIB_DATA  = nib_data_q;
  assign NIB_FIRST = nib_first_q;
  assign FLAGS     = flags_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_ym_pcma_sched.sv
// Directed bench for ym_pcma_sched; expected nibbles are queued when a slot is
// driven and compared by a monitor when NIB_VALID appears.
module tb_ym_pcma_sched;

  logic        phi_m = 1'b0;
  logic        reset = 1'b1;
  logic        slot_tick = 1'b0;
  logic [5:0]  keyon = '0, keyoff = '0, flagmask = '0, flag_clr = '0;
  logic [95:0] start = '0, stop = '0;
  logic        rom_ack = 1'b0;
  logic [7:0]  rom_data = '0;
  logic        rom_req, nib_valid, nib_first, overrun;
  logic [23:0] rom_addr;
  logic [2:0]  nib_ch;
  logic [3:0]  nib_data;
  logic [5:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_e;

  ym_pcma_sched dut (
    .PHI_M(phi_m), .RESET(reset), .SLOT_TICK(slot_tick),
    .KEYON(keyon), .KEYOFF(keyoff), .START(start), .STOP(stop),
    .FLAGMASK(flagmask), .FLAG_CLR(flag_clr),
    .ROM_REQ(rom_req), .ROM_ADDR(rom_addr), .ROM_ACK(rom_ack), .ROM_DATA(rom_data),
    .NIB_VALID(nib_valid), .NIB_CH(nib_ch), .NIB_DATA(nib_data), .NIB_FIRST(nib_first),
    .FLAGS(flags), .OVERRUN(overrun)
  );

  always #5 phi_m = ~phi_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each emitted nibble must match the oldest expectation.
  always @(negedge phi_m) begin
    if (nib_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL nib_unexpected: observed ch=%0d data=%0h expected no nibble", nib_ch, nib_data);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("nib_ch_data_first", {24'd0, nib_ch, nib_data, nib_first}, {24'd0, exp_e});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(negedge phi_m);
  endtask

  task automatic tick();
    slot_tick = 1'b1;
    cyc();
    slot_tick = 1'b0;
  endtask

  task automatic pulse_key(input logic [5:0] on, input logic [5:0] off);
    keyon = on;
    keyoff = off;
    cyc();
    keyon = '0;
    keyoff = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, rom_req, 0);
    check({tag, "_vld"}, nib_valid, 0);
    check({tag, "_first"}, nib_first, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_flags"}, flags, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_ch"}, nib_ch, 0);
    check({tag, "_data"}, nib_data, 0);
  endtask

  // Slot for an inactive channel: nothing may be emitted or fetched.
  task automatic serve_idle(input string tag);
    tick();
    cyc();
    check({tag, "_vld"}, nib_valid, 0);
    check({tag, "_req"}, rom_req, 0);
  endtask

  task automatic idle5(input string tag);
    for (int k = 0; k < 5; k++) serve_idle(tag);
  endtask

  task automatic serve_fetch(input string tag, input logic [2:0] ch, input logic [23:0] addr,
                             input logic [7:0] data, input logic first, input int delay);
    exp_q.push_back({ch, data[7:4], first});
    tick();
    cyc();
    check({tag, "_req"}, rom_req, 1);
    check({tag, "_addr"}, rom_addr, addr);
    for (int k = 0; k < delay; k++) begin
      cyc();
      check({tag, "_req_hold"}, rom_req, 1);
      check({tag, "_addr_hold"}, rom_addr, addr);
    end
    rom_ack = 1'b1;
    rom_data = data;
    cyc();
    rom_ack = 1'b0;
    check({tag, "_vld"}, nib_valid, 1);
    check({tag, "_req_drop"}, rom_req, 0);
    cyc();
    check({tag, "_vld_end"}, nib_valid, 0);
  endtask

  task automatic serve_buf(input string tag, input logic [2:0] ch, input logic [3:0] nib,
                           input logic [5:0] clr);
    exp_q.push_back({ch, nib, 1'b0});
    tick();
    flag_clr = clr;
    cyc();
    flag_clr = '0;
    check({tag, "_vld"}, nib_valid, 1);
    check({tag, "_req"}, rom_req, 0);
    cyc();
    check({tag, "_vld_end"}, nib_valid, 0);
  endtask

  // Key ch0 on at 0x001200 and play it through to 0x0012FF; ch1..5 idle.
  task automatic run_to_stop(input string tag, input logic clr_last);
    for (int b = 0; b < 256; b++) begin
      logic [7:0] d;
      d = 8'(b) ^ 8'h5A;
      serve_fetch({tag, "_hi"}, 3'd0, {16'h0012, 8'(b)}, d, (b == 0), 0);
      idle5({tag, "_gap"});
      serve_buf({tag, "_lo"}, 3'd0, d[3:0], (b == 255 && clr_last) ? 6'h01 : 6'h00);
      idle5({tag, "_gap"});
    end
  endtask

  initial begin
    repeat (3) cyc();
    check_reset("reset");
    reset = 1'b0;
    cyc();

    start[15:0]  = 16'h0012;
    stop[15:0]   = 16'h0012;
    start[95:80] = 16'h8000;
    stop[95:80]  = 16'h8000;

    // Simultaneous key-on/key-off on ch2: key-off wins, ch2 stays silent.
    pulse_key(6'h04, 6'h04);

    // Basic fetch on ch0, then its buffered low nibble one rotation later.
    pulse_key(6'h01, 6'h00);
    serve_fetch("basic_hi", 3'd0, 24'h001200, 8'hA7, 1'b1, 2);
    idle5("basic_gap");
    serve_buf("basic_lo", 3'd0, 4'h7, 6'h00);

    // Round-robin with ch0 and ch5 active.
    pulse_key(6'h20, 6'h00);
    for (int k = 0; k < 4; k++) serve_idle("rr_pre");
    serve_fetch("rr_ch5_hi", 3'd5, 24'h800000, 8'h3C, 1'b1, 0);
    serve_fetch("rr_ch0_hi", 3'd0, 24'h001201, 8'h96, 1'b0, 1);
    for (int k = 0; k < 4; k++) serve_idle("rr_mid");
    serve_buf("rr_ch5_lo", 3'd5, 4'hC, 6'h00);
    serve_buf("rr_wrap_ch0", 3'd0, 4'h6, 6'h00);
    pulse_key(6'h00, 6'h20);

    // Overrun: tick during a FETCH whose ACK comes after 5 request cycles.
    idle5("ovr_pre");
    exp_q.push_back({3'd0, 4'h1, 1'b0});
    tick();
    cyc();
    check("ovr_req", rom_req, 1);
    check("ovr_addr", rom_addr, 24'h001202);
    slot_tick = 1'b1;
    cyc();
    slot_tick = 1'b0;
    check("ovr_pulse", overrun, 1);
    check("ovr_req_hold", rom_req, 1);
    cyc();
    check("ovr_pulse_end", overrun, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("ovr_req_wait", rom_req, 1);
    end
    rom_ack = 1'b1;
    rom_data = 8'h1E;
    cyc();
    rom_ack = 1'b0;
    check("ovr_vld", nib_valid, 1);
    cyc();
    idle5("ovr_ptr");
    serve_buf("ovr_ptr_ch0", 3'd0, 4'hE, 6'h00);

    // End flag, with FLAG_CLR colliding with the flag-set event.
    idle5("ef_pre");
    pulse_key(6'h01, 6'h00);
    run_to_stop("ef", 1'b1);
    check("ef_flag_set_wins", flags, 6'h01);
    serve_idle("ef_ch0_inactive");
    idle5("ef_post");
    flag_clr = 6'h01;
    cyc();
    flag_clr = '0;
    check("ef_flag_clr", flags, 6'h00);

    // Same run with the flag masked.
    flagmask = 6'h01;
    pulse_key(6'h01, 6'h00);
    run_to_stop("mask", 1'b0);
    check("mask_flag", flags, 6'h00);
    serve_idle("mask_ch0_inactive");
    idle5("mask_post");

    // Reset in the middle of a FETCH; a late ACK must be ignored.
    pulse_key(6'h01, 6'h00);
    tick();
    cyc();
    check("rst_req_before", rom_req, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset("rst_fetch");
    rom_ack = 1'b1;
    rom_data = 8'hFF;
    cyc();
    rom_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rst_late_ack_vld", nib_valid, 0);
    end
    serve_idle("rst_ch0_inactive");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
